// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: data width, FSM state and
// bus-owner encodings, and the load/store streak helper.
package mem_bus_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int STREAK_W = 4;

    // Fetches always read a full word.
    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    // Saturating increment of the load/store streak counter.
    function automatic logic [STREAK_W-1:0] streak_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] limit
    );
        if (cur >= limit) begin
            return limit;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus wait watchdog: counts BUS cycles without an acknowledge and flags a
// timeout on the cycle the count reaches TIMEOUT_CYCLES. Only built when
// MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    input  logic i_bus_ack,
    output logic o_timeout
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens on
    // the edge that would otherwise make it TIMEOUT_CYCLES.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Clear outside BUS so every transaction starts from zero; count stalls.
    always_comb begin
        cnt_next = cnt_reg;
        if (!i_busy) begin
            cnt_next = '0;
        end else if (!i_bus_ack && (cnt_reg != CNT_LAST)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A real acknowledge in the same cycle always wins over the timeout.
    assign o_timeout = i_busy && !i_bus_ack && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one memory bus between instruction fetch and
// load/store. One transaction at a time, IDLE -> BUS -> RESP. Load/store has
// priority, but after MAX_LS_STREAK consecutive load/store grants with fetch
// waiting, fetch is forced through.
// Optional: define MEM_ARB_TIMEOUT_EN to abort stalled bus cycles with an
// error after TIMEOUT_CYCLES; otherwise both error outputs are tied to 0.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LS_STREAK  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic [XLEN-1:0] o_if_rdata,
    output logic            o_if_err,
    input  logic            i_ls_req,
    input  logic            i_ls_we,
    input  logic [3:0]      i_ls_be,
    input  logic [XLEN-1:0] i_ls_addr,
    input  logic [XLEN-1:0] i_ls_wdata,
    output logic            o_ls_ack,
    output logic [XLEN-1:0] o_ls_rdata,
    output logic            o_ls_err,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    if ((MAX_LS_STREAK < 1) || (MAX_LS_STREAK > 15)) begin : g_bad_streak
        $error("mem_bus_arbiter: MAX_LS_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t           state_reg,     state_next;
    arb_owner_t           owner_reg,     owner_next;
    logic [STREAK_W-1:0]  streak_reg,    streak_next;
    logic                 bus_req_reg,   bus_req_next;
    logic                 bus_we_reg,    bus_we_next;
    logic [3:0]           bus_be_reg,    bus_be_next;
    logic [XLEN-1:0]      bus_addr_reg,  bus_addr_next;
    logic [XLEN-1:0]      bus_wdata_reg, bus_wdata_next;
    logic                 if_ack_reg,    if_ack_next;
    logic [XLEN-1:0]      if_rdata_reg,  if_rdata_next;
    logic                 ls_ack_reg,    ls_ack_next;
    logic [XLEN-1:0]      ls_rdata_reg,  ls_rdata_next;

`ifdef MEM_ARB_TIMEOUT_EN
    logic if_err_reg, if_err_next;
    logic ls_err_reg, ls_err_next;
    logic bus_timeout;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_busy    (state_reg == ST_BUS),
        .i_bus_ack (i_bus_ack),
        .o_timeout (bus_timeout)
    );
`endif

    // Next-state, arbitration and registered-output logic.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        streak_next    = streak_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_be_next    = bus_be_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        if_ack_next    = 1'b0;
        ls_ack_next    = 1'b0;
        if_rdata_next  = if_rdata_reg;
        ls_rdata_next  = ls_rdata_reg;
`ifdef MEM_ARB_TIMEOUT_EN
        if_err_next    = 1'b0;
        ls_err_next    = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Load/store wins unless fetch has waited out a full streak.
                if (i_ls_req && !(i_if_req && (streak_reg == STREAK_MAX))) begin
                    state_next     = ST_BUS;
                    owner_next     = OWN_LS;
                    bus_req_next   = 1'b1;
                    bus_we_next    = i_ls_we;
                    bus_be_next    = i_ls_be;
                    bus_addr_next  = i_ls_addr;
                    bus_wdata_next = i_ls_wdata;
                    streak_next    = i_if_req ? streak_inc(streak_reg, STREAK_MAX) : '0;
                end else if (i_if_req) begin
                    state_next     = ST_BUS;
                    owner_next     = OWN_IF;
                    bus_req_next   = 1'b1;
                    bus_we_next    = 1'b0;
                    bus_be_next    = BE_FULL;
                    bus_addr_next  = i_if_addr;
                    bus_wdata_next = '0;
                    streak_next    = '0;
                end else begin
                    streak_next    = '0;
                end
            end
            ST_BUS: begin
                // Payload stays frozen until the slave acknowledges.
                if (i_bus_ack) begin
                    state_next   = ST_RESP;
                    bus_req_next = 1'b0;
                    if (owner_reg == OWN_IF) begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = i_bus_rdata;
                    end else begin
                        ls_ack_next   = 1'b1;
                        ls_rdata_next = i_bus_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (bus_timeout) begin
                    state_next   = ST_RESP;
                    bus_req_next = 1'b0;
                    if (owner_reg == OWN_IF) begin
                        if_ack_next   = 1'b1;
                        if_err_next   = 1'b1;
                        if_rdata_next = '0;
                    end else begin
                        ls_ack_next   = 1'b1;
                        ls_err_next   = 1'b1;
                        ls_rdata_next = '0;
                    end
                end
`endif
            end
            ST_RESP: begin
                // Ack is visible this cycle; the requester drops req next.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_IF;
            streak_reg    <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_be_reg    <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            if_rdata_reg  <= '0;
            ls_ack_reg    <= 1'b0;
            ls_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            streak_reg    <= streak_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_be_reg    <= bus_be_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            if_ack_reg    <= if_ack_next;
            if_rdata_reg  <= if_rdata_next;
            ls_ack_reg    <= ls_ack_next;
            ls_rdata_reg  <= ls_rdata_next;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Error flags, valid alongside the owner's ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if_err_reg <= 1'b0;
            ls_err_reg <= 1'b0;
        end else begin
            if_err_reg <= if_err_next;
            ls_err_reg <= ls_err_next;
        end
    end

    assign o_if_err = if_err_reg;
    assign o_ls_err = ls_err_reg;
`else
    assign o_if_err = 1'b0;
    assign o_ls_err = 1'b0;
`endif

    assign o_bus_req   = bus_req_reg;
    assign o_bus_we    = bus_we_reg;
    assign o_bus_be    = bus_be_reg;
    assign o_bus_addr  = bus_addr_reg;
    assign o_bus_wdata = bus_wdata_reg;
    assign o_if_ack    = if_ack_reg;
    assign o_if_rdata  = if_rdata_reg;
    assign o_ls_ack    = ls_ack_reg;
    assign o_ls_rdata  = ls_rdata_reg;

endmodule
